// File: rtl/uart_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader_ctrl
// Brief    : Parses UART-assembled words as one download frame (length,
//            payload, checksum). It writes the payload to IMEM and releases
//            the core reset when the checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader_ctrl #(
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  load_done,
    output logic                  load_error,
    output logic [2:0]            state_o
);

    // The count must be able to hold MAX_WORDS, which may equal 2**ADDR_WIDTH.
    localparam int c_CW = ADDR_WIDTH + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] c_WAIT_LEN = 3'd0;
    localparam logic [2:0] c_LOAD     = 3'd1;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_DONE     = 3'd3;
    localparam logic [2:0] c_ERROR    = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_CW-1:0]       r_len;
    logic [c_CW-1:0]       r_count;
    logic [31:0]           r_sum;
    logic [c_TW-1:0]       r_idle;
    logic                  w_timeout;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_cpu_reset_n;
    logic                  r_load_done;
    logic                  r_load_error;

    assign w_timeout = (r_idle == c_TW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_WAIT_LEN;
        else          r_state <= w_next;
    end

    // Next-state logic: restart dominates, and a word arriving in the same cycle as the timeout wins.
    always_comb begin
        w_next = r_state;
        if (restart) begin
            w_next = c_WAIT_LEN;
        end else begin
            case (r_state)
                c_WAIT_LEN: if (word_valid) begin
                    if (word_data == 32'd0)                 w_next = c_CHECK;
                    else if (word_data > 32'(MAX_WORDS))    w_next = c_ERROR;
                    else                                    w_next = c_LOAD;
                end
                c_LOAD: begin
                    if (word_valid) begin
                        if (r_count + c_CW'(1) == r_len)    w_next = c_CHECK;
                    end else if (w_timeout) begin
                        w_next = c_ERROR;
                    end
                end
                c_CHECK: begin
                    if (word_valid)     w_next = (word_data == r_sum) ? c_DONE : c_ERROR;
                    else if (w_timeout) w_next = c_ERROR;
                end
                c_DONE:  w_next = c_DONE;
                c_ERROR: w_next = c_ERROR;
                default: w_next = c_WAIT_LEN;
            endcase
        end
    end

    // Frame datapath: length latch, payload count/sum and the registered IMEM write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len        <= '0;
            r_count      <= '0;
            r_sum        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (restart) begin
                r_len   <= '0;
                r_count <= '0;
                r_sum   <= '0;
            end else if (word_valid && r_state == c_WAIT_LEN) begin
                // Oversized lengths go to ERROR, so truncation never loses a valid length.
                r_len   <= word_data[c_CW-1:0];
                r_count <= '0;
                r_sum   <= '0;
            end else if (word_valid && r_state == c_LOAD) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_count[ADDR_WIDTH-1:0];
                r_imem_wdata <= word_data;
                r_sum        <= r_sum + word_data;
                r_count      <= r_count + c_CW'(1);
            end
        end
    end

    // Inter-word idle counter. It runs only while a frame body is expected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_idle <= '0;
        else if (restart || word_valid || (w_next != r_state))
            r_idle <= '0;
        else if (r_state == c_LOAD || r_state == c_CHECK)
            r_idle <= r_idle + c_TW'(1);
    end

    // Status outputs follow the state register by one cycle; restart clears them at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_reset_n <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_cpu_reset_n <= !restart && (r_state == c_DONE);
            r_load_done   <= !restart && (r_state == c_DONE);
            r_load_error  <= !restart && (r_state == c_ERROR);
        end
    end

    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign cpu_reset_n = r_cpu_reset_n;
    assign load_done   = r_load_done;
    assign load_error  = r_load_error;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader_ctrl
// Brief    : Self-checking bench for uart_boot_loader_ctrl. It applies
//            directed frame vectors, corner sequences and random frames.
//            Results are checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader_ctrl;

    localparam int c_AW = 4;
    localparam int c_MW = 16;
    localparam int c_TO = 50;

    localparam logic [2:0] c_S_WAIT = 3'd0;
    localparam logic [2:0] c_S_LOAD = 3'd1;
    localparam logic [2:0] c_S_DONE = 3'd3;
    localparam logic [2:0] c_S_ERR  = 3'd4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            word_valid = 1'b0;
    logic [31:0]     word_data = '0;
    logic            restart = 1'b0;
    logic            imem_we;
    logic [c_AW-1:0] imem_addr;
    logic [31:0]     imem_wdata;
    logic            cpu_reset_n;
    logic            load_done;
    logic            load_error;
    logic [2:0]      state_o;

    uart_boot_loader_ctrl #(
        .ADDR_WIDTH(c_AW), .MAX_WORDS(c_MW), .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .word_valid(word_valid), .word_data(word_data),
        .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_error(load_error),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_AW-1:0] addr;
        logic [31:0]     data;
    } wr_t;

    typedef struct {
        logic [31:0]       len;
        int                nsend;
        logic [3:0][31:0]  w;
        logic [31:0]       cs;
        logic [2:0]        exp_state;
        int                exp_writes;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    wr_t         wq[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[6];

    // Scoreboard capture of every IMEM write, sampled mid-cycle.
    always @(negedge clk) if (imem_we) wq.push_back('{imem_addr, imem_wdata});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        word_valid = 1'b1;
        word_data  = w;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wq.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " write count"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 32'(wq[i].addr), 32'(i));
            chk($sformatf("%s data[%0d]", tag, i), wq[i].data, exp_q[i]);
        end
    endtask

    task automatic check_status(input string tag, input logic [2:0] st);
        chk({tag, " state"}, 32'(state_o), 32'(st));
        chk({tag, " load_done"}, 32'(load_done), 32'(st == c_S_DONE));
        chk({tag, " load_error"}, 32'(load_error), 32'(st == c_S_ERR));
        chk({tag, " cpu_reset_n"}, 32'(cpu_reset_n), 32'(st == c_S_DONE));
    endtask

    function automatic vec_t mk(input logic [31:0] len, input int nsend,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] cs, input logic [2:0] st, input int nw);
        vec_t v;
        v.len = len; v.nsend = nsend;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.cs = cs; v.exp_state = st; v.exp_writes = nw;
        return v;
    endfunction

    initial begin
        logic [31:0] sum;
        logic [31:0] len;
        logic [31:0] w;
        logic [2:0]  st;
        int          nw;
        logic        bad;

        vecs[0] = mk(32'd3, 3, 32'h11, 32'h22, 32'h33, 0, 32'h66, c_S_DONE, 3);
        vecs[1] = mk(32'd2, 2, 32'hFFFF_FFFF, 32'h2, 0, 0, 32'h1, c_S_DONE, 2);
        vecs[2] = mk(32'd2, 2, 32'd5, 32'd6, 0, 0, 32'd12, c_S_ERR, 2);
        vecs[3] = mk(32'(c_MW + 1), 2, 32'hA, 32'hB, 0, 0, 32'h15, c_S_ERR, 0);
        vecs[4] = mk(32'd0, 0, 0, 0, 0, 0, 32'd0, c_S_DONE, 0);
        vecs[5] = mk(32'd0, 0, 0, 0, 0, 0, 32'd1, c_S_ERR, 0);

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        check_status("reset", c_S_WAIT);
        chk("reset imem_we", 32'(imem_we), 0);
        chk("reset imem_addr", 32'(imem_addr), 0);
        chk("reset imem_wdata", imem_wdata, 0);
        gap(2);
        reset_n = 1'b1;
        gap(1);

        // Directed frame table.
        for (int v = 0; v < 6; v++) begin
            do_restart();
            exp_q.delete();
            for (int i = 0; i < vecs[v].exp_writes; i++) exp_q.push_back(vecs[v].w[i]);
            send(vecs[v].len);
            for (int i = 0; i < vecs[v].nsend; i++) begin
                gap(v);
                send(vecs[v].w[i]);
            end
            send(vecs[v].cs);
            chk($sformatf("vec%0d state", v), 32'(state_o), 32'(vecs[v].exp_state));
            if (vecs[v].exp_state == c_S_DONE)
                chk($sformatf("vec%0d done lag", v), 32'(load_done), 0);
            gap(1);
            check_status($sformatf("vec%0d", v), vecs[v].exp_state);
            check_writes($sformatf("vec%0d", v));
        end

        // Inter-word timeout.
        do_restart();
        send(32'd4);
        send(32'hDEAD_0001);
        gap(c_TO - 1);
        chk("timeout before", 32'(state_o), 32'(c_S_LOAD));
        gap(1);
        chk("timeout at", 32'(state_o), 32'(c_S_ERR));
        gap(1);
        check_status("timeout", c_S_ERR);
        chk("timeout writes", 32'(wq.size()), 1);

        // Restart coincident with a payload word drops the word.
        do_restart();
        send(32'd4);
        send(32'h0000_0A01);
        send(32'h0000_0A02);
        @(negedge clk);
        word_valid = 1'b1; word_data = 32'h0000_0A03; restart = 1'b1;
        @(negedge clk);
        word_valid = 1'b0; restart = 1'b0;
        gap(1);
        check_status("coinc", c_S_WAIT);
        chk("coinc writes", 32'(wq.size()), 2);
        wq.delete();
        exp_q.delete();
        exp_q.push_back(32'h77); exp_q.push_back(32'h88); exp_q.push_back(32'h99);
        send(32'd3); send(32'h77); send(32'h88); send(32'h99); send(32'h198);
        gap(1);
        check_status("after coinc", c_S_DONE);
        check_writes("after coinc");

        // Asynchronous reset mid-LOAD while a write strobe is active.
        do_restart();
        send(32'd4);
        send(32'h1234_5678);
        chk("pre-reset imem_we", 32'(imem_we), 1);
        #1 reset_n = 1'b0;
        #1;
        check_status("async reset", c_S_WAIT);
        chk("async imem_we", 32'(imem_we), 0);
        chk("async imem_addr", 32'(imem_addr), 0);
        chk("async imem_wdata", imem_wdata, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Random frames against the frame-level model.
        for (int f = 0; f < 30; f++) begin
            do_restart();
            exp_q.delete();
            len = 32'($urandom_range(0, c_MW + 2));
            bad = ($urandom_range(0, 3) == 0);
            sum = '0;
            send(len);
            nw = (len > 32'(c_MW)) ? 2 : int'(len);
            for (int i = 0; i < nw; i++) begin
                w = $urandom();
                gap($urandom_range(0, 8));
                send(w);
                if (len <= 32'(c_MW)) begin
                    exp_q.push_back(w);
                    sum = sum + w;
                end
            end
            gap($urandom_range(0, 8));
            send(bad ? sum + 32'd1 : sum);
            if (len > 32'(c_MW) || bad) st = c_S_ERR;
            else                        st = c_S_DONE;
            gap(1);
            check_status($sformatf("rnd%0d", f), st);
            check_writes($sformatf("rnd%0d", f));
            send($urandom());
            gap(1);
            chk($sformatf("rnd%0d ignore state", f), 32'(state_o), 32'(st));
            chk($sformatf("rnd%0d ignore writes", f), 32'(wq.size()), 32'(exp_q.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
